// File: rtl/apb2mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb2mem_pkg
// Brief    : Shared types for the APB-to-native-memory completer bridge.
// Revision : 1.0
// ============================================================================
package apb2mem_pkg;

    localparam int TMO_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } nmi_req_t;

endpackage
`default_nettype wire

// File: rtl/apb2mem.sv
`default_nettype none
// ============================================================================
// Module   : apb2mem
// Brief    : APB4 completer turning each transfer into one nmi master access,
//            with address-window check and response timeout on pslverr.
// Revision : 1.0
// ============================================================================
module apb2mem
    import apb2mem_pkg::*;
#(
    parameter logic [31:0] WIN_BASE   = 32'h0000_0000,
    parameter logic [31:0] WIN_MASK   = 32'hFFFF_FFFF,
    parameter int          TMO_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] apb_paddr_i,
    input  logic [2:0]  apb_pprot_i,
    input  logic        apb_psel_i,
    input  logic        apb_penable_i,
    input  logic        apb_pwrite_i,
    input  logic [31:0] apb_pwdata_i,
    input  logic [3:0]  apb_pstrb_i,
    output logic        apb_pready_o,
    output logic [31:0] apb_prdata_o,
    output logic        apb_pslverr_o,
    output logic        mem_valid_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TMO_CYCLES - 1);
    localparam logic [TMO_W-1:0] CNT_MAX   = {TMO_W{1'b1}};

    state_e            state_q, state_d;
    nmi_req_t          req_q, req_d;
    logic              valid_q, valid_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [31:0]       prdata_q, prdata_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;

    logic              setup_w;
    logic              hit_w;
    logic              unused_pprot_w;

    assign setup_w        = apb_psel_i & ~apb_penable_i;
    assign hit_w          = ((apb_paddr_i & WIN_MASK) == (WIN_BASE & WIN_MASK));
    assign unused_pprot_w = ^apb_pprot_i;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        valid_d   = valid_q;
        pready_d  = 1'b0;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (setup_w) begin
                    if (hit_w) begin
                        req_d.addr  = apb_paddr_i;
                        req_d.wdata = apb_pwdata_i;
                        req_d.wstrb = apb_pwrite_i ? apb_pstrb_i : 4'h0;
                        valid_d     = 1'b1;
                        cnt_d       = '0;
                        state_d     = REQ;
                    end else begin
                        // Out-of-window: answer with an error, never touch nmi
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        prdata_d  = '0;
                        state_d   = RESP;
                    end
                end
            end
            REQ: begin
                // A ready on the limit cycle still counts as a normal completion
                if (mem_ready_i) begin
                    valid_d   = 1'b0;
                    prdata_d  = (req_q.wstrb == 4'h0) ? mem_rdata_i : 32'h0;
                    pslverr_d = 1'b0;
                    pready_d  = 1'b1;
                    state_d   = RESP;
                end else if (cnt_q == TMO_LIMIT) begin
                    valid_d   = 1'b0;
                    prdata_d  = '0;
                    pslverr_d = 1'b1;
                    pready_d  = 1'b1;
                    state_d   = RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end
            RESP: begin
                pslverr_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            req_q     <= '0;
            valid_q   <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            cnt_q     <= cnt_d;
        end
    end

    assign apb_pready_o  = pready_q;
    assign apb_pslverr_o = pslverr_q;
    assign apb_prdata_o  = prdata_q;
    assign mem_valid_o   = valid_q;
    assign mem_addr_o    = req_q.addr;
    assign mem_wdata_o   = req_q.wdata;
    assign mem_wstrb_o   = req_q.wstrb;

endmodule
`default_nettype wire

// File: doc/apb2mem.md
Name: apb2mem

Overview:
- APB4 completer (slave) that converts each APB transfer into one native-memory-interface (nmi) master transaction (valid/addr/wdata/wstrb, then ready/rdata). It is the reverse of the existing mem2apb initiator bridge.
- Lets an external APB host, such as a debug or test APB port, reach the SoC native bus (SRAM, peripherals).
- Adds an address-window check and a response timeout, both reported as pslverr.

Parameters:
- WIN_BASE, 32'h0000_0000, base of accepted APB address window.
- WIN_MASK, 32'hFFFF_FFFF, address bits compared against WIN_BASE; a transfer hits when (paddr & WIN_MASK) == (WIN_BASE & WIN_MASK).
- TMO_CYCLES, 256, maximum cycles mem_valid_o stays high without mem_ready_i before aborting; range 1..65535.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-high.
- apb_paddr_i  in  32  APB address.
- apb_pprot_i  in  3  accepted, unused.
- apb_psel_i  in  1  APB select.
- apb_penable_i  in  1  APB enable.
- apb_pwrite_i  in  1  1 = write.
- apb_pwdata_i  in  32  write data.
- apb_pstrb_i  in  4  write byte strobes.
- apb_pready_o  out  1  transfer complete.
- apb_prdata_o  out  32  read data.
- apb_pslverr_o  out  1  error response.
- mem_valid_o  out  1  nmi request valid.
- mem_addr_o  out  32  nmi address.
- mem_wdata_o  out  32  nmi write data.
- mem_wstrb_o  out  4  nmi strobes; 0 = read.
- mem_rdata_i  in  32  nmi read data.
- mem_ready_i  in  1  nmi completion.

Behaviour:
- Reset (async, rst_i=1) clears:
  - all outputs to 0: pready, pslverr, prdata, mem_valid, mem_addr, mem_wdata, mem_wstrb;
  - FSM to IDLE;
  - timeout counter to 0.
- Reset mid-transaction drops mem_valid_o immediately; no completion is issued.
- All outputs are registered.
- FSM states are IDLE, REQ, RESP.
- IDLE, on psel=1 & penable=0 (setup):
  - window hit: capture paddr, pwdata, and wstrb = pwrite ? pstrb : 4'h0 into mem_* regs; set mem_valid_o; go to REQ.
  - window miss: go to RESP with pslverr=1, prdata=0; no nmi request is issued.
- REQ:
  - mem_valid_o and mem_* stay stable until completion.
  - On mem_ready_i=1: clear mem_valid_o; prdata <= wstrb==0 ? mem_rdata_i : 0; pslverr=0; pready=1; go to RESP.
  - Timeout: the counter increments each REQ cycle. When it reaches TMO_CYCLES-1 with no ready, clear mem_valid_o, set pready=1, pslverr=1, prdata=0, go to RESP.
  - mem_ready_i arriving in the same cycle as the timeout limit wins, giving a normal completion.
- RESP:
  - pready is high for exactly one cycle.
  - Next edge: pready=0, pslverr=0, go to IDLE.
  - prdata holds until the next completion.
- Latency:
  - setup at cycle S; mem_valid_o high from S+1.
  - ready sampled at cycle R gives pready=1 at R+1.
  - Minimum 1 APB wait state (ready at S+1 gives pready at S+2).
- Back-to-back: the next setup is legal the cycle after the RESP cycle, when the FSM is back in IDLE. No transfer is lost.
- mem_ready_i outside REQ is ignored.
- APB protocol violations:
  - psel dropped during REQ: the nmi access still completes and pready pulses once.
  - setup seen outside IDLE: ignored.
- The timeout counter is 16 bits, cleared on entry to REQ, and does not wrap.

Decomposition:
- Package apb2mem_pkg holds:
  - state_e enum {IDLE, REQ, RESP};
  - localparam TMO_W=16;
  - typedef nmi_req_t struct {addr, wdata, wstrb}.
- Single module; no sub-module needed. The timeout counter is inline.
- The SoC top connects mem_* to an nmi_if master port.

Test Plan:
- Write: paddr=32'h1000_0010, pwdata=32'hA5A5_1234, pstrb=4'h3, mem_ready at S+1 -> mem_valid S+1 with addr 32'h1000_0010, wdata 32'hA5A5_1234, wstrb 4'h3; pready=1 at S+2, pslverr=0.
- Read: paddr=32'h1000_0020, mem_ready after 5 cycles with rdata=32'hDEAD_BEEF -> wstrb=0; pready=1 one cycle after ready; prdata=32'hDEAD_BEEF; pslverr=0.
- Window miss: WIN_BASE=32'h1000_0000, WIN_MASK=32'hF000_0000, paddr=32'h2000_0000 -> mem_valid never rises; pready=1 at S+1, pslverr=1, prdata=0.
- Timeout: TMO_CYCLES=8, mem_ready held 0 -> mem_valid high exactly 8 cycles, then pready=1 with pslverr=1 and prdata=0. A later ready pulse is ignored, and the next transfer completes normally.
- Back-to-back: write then read with no idle cycle between APB transfers -> two distinct nmi requests in order, each with a single-cycle pready.
- Reset mid-REQ: assert rst_i while mem_valid=1 -> mem_valid and pready drop asynchronously. After release, a new read completes normally.
